// File: rtl/poci_pkg.sv
// Shared defaults, derived frame geometry and FSM state type for the POCI serial scheduler.
package poci_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned MSG_W_DEF = 8;

    function automatic int unsigned id_width(input int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Start bit + requester ID + message + parity.
    function automatic int unsigned frame_len(input int unsigned n_req, input int unsigned msg_w);
        return 1 + id_width(n_req) + msg_w + 1;
    endfunction

    localparam int unsigned ID_W_DEF      = id_width(N_REQ_DEF);
    localparam int unsigned FRAME_LEN_DEF = frame_len(N_REQ_DEF, MSG_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/poci_rr_arb.sv
// Combinational round-robin picker: first active request at or after the pointer, wrapping.
module poci_rr_arb
    import poci_pkg::*;
#(
    parameter  int unsigned N_REQ = N_REQ_DEF,
    localparam int unsigned ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt_c,
    output logic [ID_W-1:0]  o_idx_c,
    output logic             o_any_c
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        o_any_c = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = (32'(i_ptr) + k >= N_REQ) ? ID_W'(32'(i_ptr) + k - N_REQ)
                                               : ID_W'(32'(i_ptr) + k);
            if (!o_any_c && i_req[w_cand]) begin
                o_any_c         = 1'b1;
                o_idx_c         = w_cand;
                o_gnt_c[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/poci_tx_sched.sv
// Arbitrates N_REQ requesters round-robin and serializes the winner's framed message
// (start, ID, message, odd parity) with a one-cycle gap between frames.
module poci_tx_sched
    import poci_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned MSG_W = MSG_W_DEF
) (
    input  logic                   sclk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*MSG_W-1:0] i_msg,
    output logic [N_REQ-1:0]       o_grant,
    output logic                   o_serial_out,
    output logic                   o_frame_valid,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned ID_W      = id_width(N_REQ);
    localparam int unsigned FRAME_LEN = frame_len(N_REQ, MSG_W);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    tx_state_t              r_state;
    logic [N_REQ-1:0]       r_grant;
    logic                   r_serial;
    logic                   r_frame_valid;
    logic                   r_busy;
    logic                   r_done;
    logic [FRAME_LEN-1:0]   r_shift;
    logic [CNT_W-1:0]       r_cnt;
    logic [ID_W-1:0]        r_ptr;

    logic [N_REQ-1:0]       w_win;
    logic [ID_W-1:0]        w_idx;
    logic                   w_any;
    logic [MSG_W-1:0]       w_msg_sel;
    logic                   w_parity;
    logic [FRAME_LEN-1:0]   w_frame;
    logic [ID_W-1:0]        w_ptr_nxt;

    poci_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_gnt_c (w_win),
        .o_idx_c (w_idx),
        .o_any_c (w_any)
    );

    // Frame is built LSB-first so bit 0 goes out on the arbitration edge.
    assign w_msg_sel = i_msg[32'(w_idx) * MSG_W +: MSG_W];
    assign w_parity  = ~(^{w_idx, w_msg_sel});
    assign w_frame   = {w_parity, w_msg_sel, w_idx, 1'b1};
    assign w_ptr_nxt = (32'(w_idx) == N_REQ - 1) ? '0 : w_idx + ID_W'(1);

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_serial      <= 1'b0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_ptr         <= '0;
        end else begin
            r_grant <= '0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_any) begin
                        r_state       <= ST_SHIFT;
                        r_grant       <= w_win;
                        r_shift       <= w_frame >> 1;
                        r_serial      <= w_frame[0];
                        r_frame_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_cnt         <= CNT_W'(1);
                        r_ptr         <= w_ptr_nxt;
                    end else begin
                        r_state       <= ST_IDLE;
                        r_serial      <= 1'b0;
                        r_frame_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == CNT_W'(FRAME_LEN)) begin
                        r_state       <= ST_GAP;
                        r_serial      <= 1'b0;
                        r_frame_valid <= 1'b0;
                        r_done        <= 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_serial <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_serial_out  = r_serial;
    assign o_frame_valid = r_frame_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule
